// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - access codes, FSM states and legality check for mem_access_ctrl
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [1:0] DMWR_NONE = 2'b00;
  localparam logic [1:0] DMWR_SW   = 2'b01;
  localparam logic [1:0] DMWR_SH   = 2'b10;
  localparam logic [1:0] DMWR_SB   = 2'b11;

  localparam logic [2:0] DMRE_NONE = 3'b000;
  localparam logic [2:0] DMRE_LW   = 3'b001;
  localparam logic [2:0] DMRE_LH   = 3'b010;
  localparam logic [2:0] DMRE_LHU  = 3'b011;
  localparam logic [2:0] DMRE_LB   = 3'b100;
  localparam logic [2:0] DMRE_LBU  = 3'b101;

  // Conflicting codes, unknown load code, or offset not aligned to the access size.
  function automatic logic access_illegal(logic [1:0] off, logic [1:0] dmwr, logic [2:0] dmre);
    logic bad;
    bad = 1'b0;
    if (dmwr != DMWR_NONE && dmre != DMRE_NONE) bad = 1'b1;
    if (dmre == 3'b110 || dmre == 3'b111) bad = 1'b1;
    if ((dmwr == DMWR_SW || dmre == DMRE_LW) && off != 2'b00) bad = 1'b1;
    if ((dmwr == DMWR_SH || dmre == DMRE_LH || dmre == DMRE_LHU) && off[0]) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte enables, store lane replication and load extract/extend
module mem_lane_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [1:0]  dmwr_i,
  input  logic [2:0]  dmre_i,
  input  logic [31:0] wdata_raw_i,
  input  logic [31:0] rdata_raw_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    rbyte = rdata_raw_i[8*off_i +: 8];
    rhalf = off_i[1] ? rdata_raw_i[31:16] : rdata_raw_i[15:0];

    be_o    = 4'b0000;
    wdata_o = 32'h0;
    case (dmwr_i)
      DMWR_SW: begin be_o = 4'b1111; wdata_o = wdata_raw_i; end
      DMWR_SH: begin
        be_o    = off_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_raw_i[15:0]}};
      end
      DMWR_SB: begin be_o = 4'b0001 << off_i; wdata_o = {4{wdata_raw_i[7:0]}}; end
      default: if (dmre_i != DMRE_NONE) be_o = 4'b1111;
    endcase

    case (dmre_i)
      DMRE_LH:  rdata_o = {{16{rhalf[15]}}, rhalf};
      DMRE_LHU: rdata_o = {16'h0, rhalf};
      DMRE_LB:  rdata_o = {{24{rbyte[7]}}, rbyte};
      DMRE_LBU: rdata_o = {24'h0, rbyte};
      default:  rdata_o = rdata_raw_i;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - runs one valid/ready bus transaction per MEM-step access
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  input  logic [1:0]  cpu_dmwr,
  input  logic [2:0]  cpu_dmre,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata
);

  state_e             state_q;
  logic [31:0]        addr_q;
  logic [1:0]         dmwr_q;
  logic [2:0]         dmre_q;
  logic [31:0]        wdata_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               valid_q;
  logic               done_q;
  logic               err_q;
  logic [31:0]        rdata_q;
  logic [31:0]        load_val;

  // Lane logic works off latched request fields, so bus fields stay stable through REQ.
  mem_lane_align u_align (
    .off_i       (addr_q[1:0]),
    .dmwr_i      (dmwr_q),
    .dmre_i      (dmre_q),
    .wdata_raw_i (wdata_q),
    .rdata_raw_i (bus_rdata),
    .be_o        (bus_be),
    .wdata_o     (bus_wdata),
    .rdata_o     (load_val)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= 32'h0;
      dmwr_q  <= DMWR_NONE;
      dmre_q  <= DMRE_NONE;
      wdata_q <= 32'h0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      case (state_q)
        ST_IDLE: if (cpu_req) begin
          addr_q  <= cpu_addr;
          dmwr_q  <= cpu_dmwr;
          dmre_q  <= cpu_dmre;
          wdata_q <= cpu_wdata;
          if (cpu_dmwr == DMWR_NONE && cpu_dmre == DMRE_NONE) begin
            state_q <= ST_RESP;
            done_q  <= 1'b1;
            err_q   <= 1'b0;
          end else if (access_illegal(cpu_addr[1:0], cpu_dmwr, cpu_dmre)) begin
            state_q <= ST_RESP;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            state_q <= ST_REQ;
            valid_q <= 1'b1;
            cnt_q   <= '0;
          end
        end
        ST_REQ: begin
          if (bus_ready) begin
            if (dmre_q != DMRE_NONE) rdata_q <= load_val;
            valid_q <= 1'b0;
            state_q <= ST_RESP;
            done_q  <= 1'b1;
            err_q   <= 1'b0;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            valid_q <= 1'b0;
            state_q <= ST_RESP;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RESP: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cpu_rdata = rdata_q;
  assign cpu_done  = done_q;
  assign cpu_err   = err_q;
  assign bus_valid = valid_q;
  assign bus_we    = (dmwr_q != DMWR_NONE);
  assign bus_addr  = {addr_q[31:2], 2'b00};

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - randomized self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0;
  logic [31:0] cpu_addr = 32'h0;
  logic [1:0]  cpu_dmwr = 2'b00;
  logic [2:0]  cpu_dmre = 3'b000;
  logic [31:0] cpu_wdata = 32'h0;
  logic [31:0] cpu_rdata;
  logic        cpu_done;
  logic        cpu_err;
  logic        bus_valid;
  logic        bus_ready = 1'b0;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = 32'h0;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_rdata = 32'h0;

  mem_access_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_dmwr  (cpu_dmwr),
    .cpu_dmre  (cpu_dmre),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_done  (cpu_done),
    .cpu_err   (cpu_err),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic int acc_size(input logic [1:0] wr, input logic [2:0] re);
    if (wr == 2'd1) return 4;
    if (wr == 2'd2) return 2;
    if (wr == 2'd3) return 1;
    case (re)
      3'd1:       return 4;
      3'd2, 3'd3: return 2;
      3'd4, 3'd5: return 1;
      default:    return 0;
    endcase
  endfunction

  // One access: waits = cycles bus_ready stays low once valid is seen.
  task automatic run(input logic [31:0] addr, input logic [1:0] wr, input logic [2:0] re,
                     input logic [31:0] wd, input logic [31:0] rd, input int waits);
    int size, off, exp_lat, exp_vcyc, cycles, vcyc;
    logic is_null, bad, exp_err, seen, fields_done;
    logic [3:0]  e_be;
    logic [31:0] e_wd, lv, mask;

    off     = int'(addr[1:0]);
    size    = acc_size(wr, re);
    is_null = (wr == 0 && re == 0);
    bad     = !is_null && ((wr != 0 && re != 0) || re > 5 || (off % size) != 0);
    if (is_null || bad) begin
      exp_lat = 1; exp_vcyc = 0; exp_err = bad;
    end else if (waits >= TIMEOUT) begin
      exp_lat = TIMEOUT + 1; exp_vcyc = TIMEOUT; exp_err = 1'b1;
    end else begin
      exp_lat = waits + 2; exp_vcyc = waits + 1; exp_err = 1'b0;
    end

    e_be = 4'hF;
    e_wd = 32'h0;
    if (wr != 0 && size > 0) begin
      e_be = 4'(((1 << size) - 1) << off);
      for (int i = 0; i < 4; i++) e_wd[8*i +: 8] = wd[8*(i % size) +: 8];
    end

    if (!exp_err && !is_null && re != 0) begin
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*size)) - 1);
      lv = (rd >> (8*off)) & mask;
      if ((re == 3'd2 || re == 3'd4) && lv[8*size-1]) lv = lv | ~mask;
      exp_rdata = lv;
    end

    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = addr; cpu_dmwr = wr; cpu_dmre = re; cpu_wdata = wd;
    bus_rdata = rd; bus_ready = 1'b0;
    @(posedge clk);
    cycles = 0; vcyc = 0; seen = 1'b0; fields_done = 1'b0;
    while (!seen && cycles < 60) begin
      @(negedge clk);
      cpu_req = 1'b0;
      cycles++;
      if (bus_valid) begin
        vcyc++;
        if (!fields_done) begin
          fields_done = 1'b1;
          check_val("bus_addr", bus_addr, {addr[31:2], 2'b00});
          check_val("bus_we", 32'(bus_we), 32'(wr != 0));
          check_val("bus_be", 32'(bus_be), 32'(e_be));
          if (wr != 0) check_val("bus_wdata", bus_wdata, e_wd);
        end
        bus_ready = (vcyc > waits);
      end else begin
        bus_ready = 1'b0;
      end
      if (cpu_done) seen = 1'b1;
    end
    check_val("done_seen", 32'(seen), 32'd1);
    check_val("latency", 32'(cycles), 32'(exp_lat));
    check_val("valid_cycles", 32'(vcyc), 32'(exp_vcyc));
    check_val("cpu_err", 32'(cpu_err), 32'(exp_err));
    check_val("cpu_rdata", cpu_rdata, exp_rdata);
    @(negedge clk);
    check_val("done_pulse", 32'(cpu_done), 32'd0);
  endtask

  initial begin
    logic late_done;
    int kind;
    logic [1:0] wr;
    logic [2:0] re;

    #12;
    check_val("rst_valid", 32'(bus_valid), 32'd0);
    check_val("rst_done", 32'(cpu_done), 32'd0);
    check_val("rst_be", 32'(bus_be), 32'd0);
    check_val("rst_rdata", cpu_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run(32'h100, 2'd1, 3'd0, 32'hDEADBEEF, 32'h0, 0);
    run(32'h103, 2'd3, 3'd0, 32'h000000A5, 32'h0, 0);
    run(32'h102, 2'd0, 3'd2, 32'h0, 32'h8001_1234, 0);
    run(32'h102, 2'd0, 3'd3, 32'h0, 32'h8001_1234, 2);
    run(32'h101, 2'd0, 3'd5, 32'h0, 32'h0000_F000, 1);
    run(32'h102, 2'd0, 3'd1, 32'h0, 32'h1111_1111, 0);
    run(32'h200, 2'd0, 3'd1, 32'h0, 32'h2222_2222, TIMEOUT);
    run(32'h300, 2'd0, 3'd0, 32'h0, 32'h0, 0);
    run(32'h300, 2'd0, 3'd6, 32'h0, 32'h0, 0);

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      wr = 2'($urandom_range(0, 3));
      re = 3'($urandom_range(0, 7));
      if (kind < 4) re = 3'd0;
      else if (kind < 8) wr = 2'd0;
      run($urandom, wr, re, $urandom, $urandom,
          ($urandom_range(0, 9) == 0) ? TIMEOUT + 2 : $urandom_range(0, 3));
    end

    // Asynchronous reset while a load is waiting on the bus.
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 32'h400; cpu_dmwr = 2'd0; cpu_dmre = 3'd1; bus_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    check_val("mid_req_valid", 32'(bus_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_val("async_valid", 32'(bus_valid), 32'd0);
    exp_rdata = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    late_done = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (cpu_done) late_done = 1'b1;
    end
    check_val("no_done_after_rst", 32'(late_done), 32'd0);
    check_val("rdata_after_rst", cpu_rdata, exp_rdata);

    run(32'h104, 2'd2, 3'd0, 32'h0000_BEEF, 32'h0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
